// File: rtl/block_dispatcher.sv
// block_dispatcher: in-order block FIFO feeding nebula cores round-robin.
// Ports: IFE offer in_*, flush, per-core busy/valid/data/id, status outputs.
module block_dispatcher #(
  parameter int NUM_CORES  = 3,
  parameter int NUM_LANES  = 2,
  parameter int WORDS      = 4,
  parameter int ID_W       = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_LANES-1:0]                  in_valid,
  input  logic [NUM_LANES-1:0][WORDS-1:0][31:0] in_data,
  input  logic [ID_W-1:0]                       in_id,
  output logic                                  in_ready,
  input  logic                                  flush,
  input  logic [NUM_CORES-1:0]                  core_busy,
  output logic [NUM_CORES-1:0]                  core_valid,
  output logic [NUM_CORES-1:0][WORDS-1:0][31:0] core_data,
  output logic [NUM_CORES-1:0][ID_W-1:0]        core_id,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_count,
  output logic [15:0]                           dispatched_total,
  output logic                                  all_idle
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] LANES_C = (PW+1)'(NUM_LANES);
  localparam logic [PW:0] ONE_P   = (PW+1)'(1);
  localparam logic [CW:0] CORES_C = (CW+1)'(NUM_CORES);
  localparam logic [CW:0] ONE_C   = (CW+1)'(1);

  typedef logic [WORDS-1:0][31:0] blk_t;

  blk_t            mem_data [FIFO_DEPTH];
  logic [ID_W-1:0] mem_id   [FIFO_DEPTH];

  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [CW-1:0]        rr_ptr;
  logic [CW-1:0]        rr_next;
  logic                 accept;
  logic [PW:0]          pushes;
  logic [PW:0]          pops;
  logic [PW:0]          avail;
  logic [PW-1:0]        wr_addr  [NUM_LANES];
  logic [PW-1:0]        sel_addr [NUM_CORES];
  logic [NUM_CORES-1:0] sel;
  logic [NUM_CORES-1:0] elig;

  assign in_ready = (DEPTH_C - fifo_count) >= LANES_C;
  assign accept   = in_ready & (|in_valid) & ~flush;
  // A core pulsed last cycle has not raised busy yet, so skip it once.
  assign elig     = ~core_busy & ~core_valid;
  assign all_idle = (fifo_count == '0) & ~(|core_busy) & ~(|core_valid);

  // Valid lanes are packed into consecutive slots in lane order.
  always_comb begin
    logic [PW:0] n;
    n = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      wr_addr[l] = wr_ptr + n[PW-1:0];
      if (in_valid[l]) n = n + ONE_P;
    end
    pushes = accept ? n : '0;
  end

  // Walk cores from rr_ptr; each eligible core takes the next oldest entry.
  always_comb begin
    logic [CW:0] c;
    logic [CW:0] cn;
    sel     = '0;
    pops    = '0;
    rr_next = rr_ptr;
    avail   = (fifo_count > LANES_C) ? LANES_C : fifo_count;
    for (int k = 0; k < NUM_CORES; k++) begin
      sel_addr[k] = '0;
    end
    for (int k = 0; k < NUM_CORES; k++) begin
      c = {1'b0, rr_ptr} + (CW+1)'(k);
      if (c >= CORES_C) c = c - CORES_C;
      cn = c + ONE_C;
      if (!flush && elig[c[CW-1:0]] && (pops < avail)) begin
        sel[c[CW-1:0]]      = 1'b1;
        sel_addr[c[CW-1:0]] = rd_ptr + pops[PW-1:0];
        pops                = pops + ONE_P;
        rr_next             = (cn == CORES_C) ? '0 : cn[CW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (in_valid[l]) begin
          mem_data[wr_addr[l]] <= in_data[l];
          mem_id[wr_addr[l]]   <= in_id;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      fifo_count       <= '0;
      rr_ptr           <= '0;
      dispatched_total <= '0;
      core_valid       <= '0;
      core_data        <= '0;
      core_id          <= '0;
    end else begin
      core_valid <= sel;
      for (int c = 0; c < NUM_CORES; c++) begin
        if (sel[c]) begin
          core_data[c] <= mem_data[sel_addr[c]];
          core_id[c]   <= mem_id[sel_addr[c]];
        end
      end
      rr_ptr           <= rr_next;
      dispatched_total <= dispatched_total + 16'(pops);
      if (flush) begin
        rd_ptr     <= wr_ptr;
        fifo_count <= '0;
      end else begin
        rd_ptr     <= rd_ptr + pops[PW-1:0];
        wr_ptr     <= wr_ptr + pushes[PW-1:0];
        fifo_count <= fifo_count + pushes - pops;
      end
    end
  end
endmodule

// File: tb/tb_block_dispatcher.sv
// tb_block_dispatcher: randomized scoreboard bench for block_dispatcher.
// Queue-level reference model; negedge monitor checks every core pulse.
module tb_block_dispatcher;
  localparam int NC  = 3;
  localparam int NL  = 2;
  localparam int W   = 4;
  localparam int IDW = 8;
  localparam int D   = 8;

  typedef logic [W-1:0][31:0] blk_t;
  typedef struct {
    logic [IDW-1:0] id;
    blk_t           data;
  } ent_t;
  typedef struct {
    int             cyc;
    int             core;
    logic [IDW-1:0] id;
    blk_t           data;
  } ev_t;

  logic                         clk = 1'b0;
  logic                         rst = 1'b0;
  logic [NL-1:0]                in_valid = '0;
  logic [NL-1:0][W-1:0][31:0]   in_data = '0;
  logic [IDW-1:0]               in_id = '0;
  logic                         in_ready;
  logic                         flush = 1'b0;
  logic [NC-1:0]                core_busy = '0;
  logic [NC-1:0]                core_valid;
  logic [NC-1:0][W-1:0][31:0]   core_data;
  logic [NC-1:0][IDW-1:0]       core_id;
  logic [$clog2(D):0]           fifo_count;
  logic [15:0]                  dispatched_total;
  logic                         all_idle;

  always #5 clk = ~clk;

  block_dispatcher #(
    .NUM_CORES(NC), .NUM_LANES(NL), .WORDS(W),
    .ID_W(IDW), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_id(in_id),
    .in_ready(in_ready), .flush(flush), .core_busy(core_busy),
    .core_valid(core_valid), .core_data(core_data), .core_id(core_id),
    .fifo_count(fifo_count), .dispatched_total(dispatched_total),
    .all_idle(all_idle)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  ent_t mq[$];
  ev_t  exq[$];
  int   m_rr = 0;
  int   m_total = 0;
  logic [NC-1:0] m_v = '0;
  blk_t da, db;
  int   saved;

  task automatic chk(string nm, logic [255:0] a, logic [255:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  // Reference: one clock edge applied to the block queue.
  task automatic step();
    int pops, last, avail, sz, c;
    ent_t got [NC];
    logic [NC-1:0] nv;
    pops = 0;
    last = 0;
    nv = '0;
    cyc++;
    sz = mq.size();
    avail = (sz < NL) ? sz : NL;
    if (!flush) begin
      for (int k = 0; k < NC; k++) begin
        c = (m_rr + k) % NC;
        if (!core_busy[c] && !m_v[c] && pops < avail) begin
          got[c] = mq.pop_front();
          nv[c] = 1'b1;
          pops++;
          last = c;
        end
      end
      if (pops > 0) m_rr = (last + 1) % NC;
      if ((D - sz) >= NL && in_valid != '0) begin
        for (int l = 0; l < NL; l++)
          if (in_valid[l]) mq.push_back('{in_id, in_data[l]});
      end
    end else begin
      mq.delete();
    end
    m_total = (m_total + pops) % 65536;
    m_v = nv;
    for (int k = 0; k < NC; k++)
      if (nv[k]) exq.push_back('{cyc, k, got[k].id, got[k].data});
  endtask

  task automatic cycle();
    @(posedge clk);
    step();
    #1;
    chk("fifo_count", 256'(fifo_count), 256'(mq.size()));
    chk("in_ready", 256'(in_ready), 256'((D - mq.size()) >= NL));
    chk("dispatched_total", 256'(dispatched_total), 256'(m_total));
    chk("all_idle", 256'(all_idle),
        256'(mq.size() == 0 && core_busy == '0 && m_v == '0));
    chk("core_valid", 256'(core_valid), 256'(m_v));
  endtask

  task automatic drive(logic [NL-1:0] v, logic [IDW-1:0] id,
                       logic [NC-1:0] b, logic f);
    in_valid = v;
    in_id = id;
    core_busy = b;
    flush = f;
    for (int l = 0; l < NL; l++)
      for (int w = 0; w < W; w++)
        in_data[l][w] = $urandom;
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        if (core_valid[c]) begin
          if (exq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_dispatch: got core %0d want none", c);
          end else begin
            e = exq.pop_front();
            chk("disp_core", 256'(c), 256'(e.core));
            chk("disp_cycle", 256'(cyc), 256'(e.cyc));
            chk("disp_id", 256'(core_id[c]), 256'(e.id));
            chk("disp_data", 256'(core_data[c]), 256'(e.data));
          end
        end
      end
      while (exq.size() != 0 && exq[0].cyc <= cyc) begin
        total++;
        bad++;
        $display("FAIL missing_dispatch: got none want core %0d id %0h",
                 exq[0].core, exq[0].id);
        void'(exq.pop_front());
      end
    end
  end

  initial begin
    #2;
    chk("rst_core_valid", 256'(core_valid), 256'(0));
    chk("rst_fifo_count", 256'(fifo_count), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_total", 256'(dispatched_total), 256'(0));
    chk("rst_all_idle", 256'(all_idle), 256'(1));
    chk("rst_core_id", 256'(core_id), 256'(0));
    chk("rst_core_data", 256'(core_data), 256'(0));
    @(negedge clk);
    rst = 1'b1;

    drive(2'b01, 8'h11, 3'b000, 1'b0);
    cycle();
    drive(2'b00, 8'h00, 3'b000, 1'b0);
    cycle();
    chk("serial_valid", 256'(core_valid), 256'(3'b001));
    chk("serial_id", 256'(core_id[0]), 256'(8'h11));
    chk("serial_total", 256'(dispatched_total), 256'(1));

    drive(2'b11, 8'h22, 3'b000, 1'b0);
    da = in_data[0];
    db = in_data[1];
    cycle();
    drive(2'b00, 8'h00, 3'b000, 1'b0);
    cycle();
    chk("par_valid", 256'(core_valid), 256'(3'b110));
    chk("par_id1", 256'(core_id[1]), 256'(8'h22));
    chk("par_id2", 256'(core_id[2]), 256'(8'h22));
    chk("par_data1", 256'(core_data[1]), 256'(da));
    chk("par_data2", 256'(core_data[2]), 256'(db));

    for (int i = 0; i < 5; i++) begin
      drive(2'b11, 8'(8'h30 + i), 3'b111, 1'b0);
      cycle();
    end
    chk("bp_count", 256'(fifo_count), 256'(8));
    chk("bp_ready", 256'(in_ready), 256'(0));
    drive(2'b00, 8'h00, 3'b000, 1'b0);
    for (int i = 0; i < 8; i++) cycle();

    for (int i = 0; i < 2; i++) begin
      drive(2'b11, 8'(8'h40 + i), 3'b111, 1'b0);
      cycle();
    end
    drive(2'b00, 8'h00, 3'b010, 1'b0);
    cycle();
    chk("holdoff_first", 256'(core_valid), 256'(3'b101));
    cycle();
    chk("holdoff_second", 256'(core_valid), 256'(3'b000));
    drive(2'b00, 8'h00, 3'b111, 1'b0);
    for (int i = 0; i < 3; i++) cycle();
    chk("busy_hold", 256'(fifo_count), 256'(2));
    drive(2'b00, 8'h00, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) cycle();

    drive(2'b11, 8'h50, 3'b111, 1'b0);
    cycle();
    drive(2'b11, 8'h51, 3'b111, 1'b0);
    cycle();
    drive(2'b01, 8'h52, 3'b111, 1'b0);
    cycle();
    chk("flush_pre", 256'(fifo_count), 256'(5));
    saved = dispatched_total;
    drive(2'b11, 8'h53, 3'b111, 1'b1);
    cycle();
    chk("flush_count", 256'(fifo_count), 256'(0));
    chk("flush_valid", 256'(core_valid), 256'(0));
    chk("flush_total", 256'(dispatched_total), 256'(saved));
    drive(2'b00, 8'h00, 3'b000, 1'b0);
    for (int i = 0; i < 2; i++) cycle();

    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom_range(0, 3)), 8'($urandom),
            3'($urandom_range(0, 7) & $urandom_range(0, 7)),
            $urandom_range(0, 31) == 0);
      cycle();
    end

    drive(2'b00, 8'h00, 3'b111, 1'b1);
    cycle();
    drive(2'b00, 8'h00, 3'b111, 1'b0);
    cycle();
    drive(2'b01, 8'h66, 3'b101, 1'b0);
    cycle();
    drive(2'b00, 8'h00, 3'b101, 1'b0);
    cycle();
    chk("pre_rst_valid", 256'(core_valid), 256'(3'b010));
    #2;
    rst = 1'b0;
    #1;
    chk("arst_valid", 256'(core_valid), 256'(0));
    chk("arst_count", 256'(fifo_count), 256'(0));
    chk("arst_ready", 256'(in_ready), 256'(1));
    chk("arst_total", 256'(dispatched_total), 256'(0));
    chk("arst_id", 256'(core_id[1]), 256'(0));
    mq.delete();
    exq.delete();
    m_rr = 0;
    m_total = 0;
    m_v = '0;
    @(negedge clk);
    rst = 1'b1;
    drive(2'b00, 8'h00, 3'b000, 1'b0);

    for (int i = 0; i < 100; i++) begin
      drive(2'($urandom_range(0, 3)), 8'($urandom),
            3'($urandom_range(0, 7) & $urandom_range(0, 7)), 1'b0);
      cycle();
    end
    drive(2'b00, 8'h00, 3'b000, 1'b0);
    for (int i = 0; i < 12; i++) cycle();
    @(negedge clk);
    #1;
    chk("drain_events", 256'(exq.size()), 256'(0));
    chk("drain_count", 256'(fifo_count), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
